// File: rtl/conv_pkg.sv
// conv_pkg
//   Shared constants and types for the convolution layer: geometry of the
//   feature map and kernel, derived output size, counter widths, the
//   signed fixed-point sample type and the sequencer state encoding.
package conv_pkg;

    localparam int n = 5;
    localparam int k = 3;
    localparam int N = 16;
    localparam int Q = 12;

    localparam int M       = n - k + 1;
    localparam int NUM_ACT = n * n;
    localparam int NUM_OUT = M * M;

    localparam int AW_IN  = $clog2(NUM_ACT);
    localparam int AW_OUT = $clog2(NUM_OUT);

    // DRAIN watchdog: give the convolver generous slack before giving up.
    localparam int WD_LIMIT = 4 * NUM_ACT;

    // The write counter must be able to hold NUM_OUT itself, which can need
    // one bit more than the write address.
    localparam int WR_CW = $clog2(NUM_OUT + 1);
    localparam int WD_CW = $clog2(WD_LIMIT + 1);

    typedef logic signed [N-1:0] fix_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/relu_stage.sv
// relu_stage
//   Registered output stage with optional ReLU. A captured result appears
//   one cycle later together with a write-valid strobe; with relu_en set,
//   negative values (sign bit high) are replaced by zero, otherwise the
//   value passes through unchanged.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   capture         take 'result' this cycle
//   relu_en         clamp negatives to zero
//   result          incoming signed sample
//   wr_valid        registered strobe, high one cycle after capture
//   wr_value        registered (possibly clamped) sample
module relu_stage
    import conv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic         relu_en,
    input  logic [N-1:0] result,
    output logic         wr_valid,
    output logic [N-1:0] wr_value
);

    fix_t value_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid <= 1'b0;
            value_q  <= '0;
        end else begin
            wr_valid <= capture;
            if (capture) begin
                value_q <= (relu_en && result[N-1]) ? '0 : fix_t'(result);
            end
        end
    end

    assign wr_value = value_q;

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer
//   Runs one full convolution pass: clears the convolver, streams all n*n
//   activations from the feature-map RAM into it, collects the M*M valid
//   results (optionally ReLU-clamped) into the output map, then pulses done.
//   err_o flags a convolver that finished early, produced surplus results,
//   or never finished.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   start_i, abort_i, relu_en_i        control (start only honoured in IDLE)
//   busy_o, done_o, err_o              status
//   rd_en_o, rd_addr_o, rd_data_i      feature-map read port (1-cycle latency)
//   conv_rst_o, conv_en_o, conv_act_o  convolver drive
//   conv_data_i, conv_val_i, conv_done_i  convolver results
//   wr_en_o, wr_addr_o, wr_data_o      output-map write port
module conv_sequencer
    import conv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              relu_en_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              rd_en_o,
    output logic [AW_IN-1:0]  rd_addr_o,
    input  logic [N-1:0]      rd_data_i,
    output logic              conv_rst_o,
    output logic              conv_en_o,
    output logic [N-1:0]      conv_act_o,
    input  logic [N-1:0]      conv_data_i,
    input  logic              conv_val_i,
    input  logic              conv_done_i,
    output logic              wr_en_o,
    output logic [AW_OUT-1:0] wr_addr_o,
    output logic [N-1:0]      wr_data_o
);

    localparam logic [AW_IN-1:0] RD_LAST = AW_IN'(NUM_ACT - 1);
    localparam logic [WR_CW-1:0] WR_FULL = WR_CW'(NUM_OUT);
    localparam logic [WR_CW-1:0] WR_LAST = WR_CW'(NUM_OUT - 1);
    localparam logic [WD_CW-1:0] WD_LAST = WD_CW'(WD_LIMIT - 1);
    localparam logic [WD_CW-1:0] WD_MAX  = WD_CW'(WD_LIMIT);

    state_t state, state_nx;

    logic [AW_IN-1:0]  rd_cnt;
    logic [WR_CW-1:0]  wr_cnt;
    logic [WD_CW-1:0]  wd_cnt;
    logic [AW_OUT-1:0] wr_addr_q;
    logic              act_val;
    logic              relu_q;
    logic              err_q;
    logic              clr_q;
    logic              capture;
    logic              err_set;
    logic              in_pass;
    logic              final_now;
    logic              starting;

    assign in_pass   = (state == STREAM) || (state == DRAIN);
    assign final_now = conv_val_i && (wr_cnt == WR_LAST);
    assign starting  = (state == IDLE) && start_i && !abort_i;

    // Next-state and event decode. A result accepted while the output map is
    // already full is an error; conv_done_i counts as early only if it does
    // not coincide with the last expected result. Abort overrides all of it.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        err_set  = 1'b0;

        if (in_pass && conv_val_i) begin
            if (wr_cnt < WR_FULL) begin
                capture = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end

        if (in_pass && conv_done_i && (wr_cnt < WR_FULL) && !final_now) begin
            err_set = 1'b1;
        end

        case (state)
            IDLE:   if (start_i) state_nx = CLEAR;
            CLEAR:  state_nx = STREAM;
            STREAM: if (rd_cnt == RD_LAST) state_nx = DRAIN;
            DRAIN: begin
                if (wr_cnt == WR_FULL) begin
                    state_nx = FINISH;
                end else if (conv_done_i) begin
                    state_nx = FINISH;
                end else if (wd_cnt == WD_LAST) begin
                    err_set  = 1'b1;
                    state_nx = FINISH;
                end
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (abort_i) begin
            state_nx = IDLE;
            capture  = 1'b0;
            err_set  = 1'b0;
        end
    end

    // State, counters and sticky flags. clr_q keeps the convolver cleared
    // for the cycle after reset or abort; act_val is the read-data valid
    // that trails rd_en_o by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            wd_cnt    <= '0;
            wr_addr_q <= '0;
            act_val   <= 1'b0;
            relu_q    <= 1'b0;
            err_q     <= 1'b0;
            clr_q     <= 1'b1;
        end else begin
            state   <= state_nx;
            clr_q   <= abort_i;
            act_val <= rd_en_o && !abort_i;

            if (starting) begin
                relu_q <= relu_en_i;
            end

            if (err_set) begin
                err_q <= 1'b1;
            end else if (starting) begin
                err_q <= 1'b0;
            end

            if (state == CLEAR) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if ((state == STREAM) && (rd_cnt != RD_LAST)) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (capture) begin
                    wr_addr_q <= wr_cnt[AW_OUT-1:0];
                    wr_cnt    <= wr_cnt + 1'b1;
                end
            end

            if (state == DRAIN) begin
                if (wd_cnt != WD_MAX) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    relu_stage u_relu (
        .clk      (clk_i),
        .rst      (rst_i),
        .capture  (capture),
        .relu_en  (relu_q),
        .result   (conv_data_i),
        .wr_valid (wr_en_o),
        .wr_value (wr_data_o)
    );

    assign busy_o     = (state != IDLE);
    assign done_o     = (state == FINISH);
    assign err_o      = err_q;
    assign rd_en_o    = (state == STREAM);
    assign rd_addr_o  = rd_en_o ? rd_cnt : '0;
    assign conv_rst_o = clr_q || (state == CLEAR);
    // After the last real activation, keep the convolver enabled on zeros
    // so its pipeline flushes out the remaining results.
    assign conv_en_o  = act_val || (state == DRAIN);
    assign conv_act_o = act_val ? rd_data_i : '0;
    assign wr_addr_o  = wr_addr_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer
//   Drives conv_sequencer against a feature-map RAM model and a behavioural
//   convolver stub (all-ones kernel, so each result is a plain window sum).
//   Expected writes are computed from the RAM contents and pushed into a
//   scoreboard queue; a negedge monitor pops and compares every write.
module tb_conv_sequencer;
    import conv_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              abort_i;
    logic              relu_en_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              rd_en_o;
    logic [AW_IN-1:0]  rd_addr_o;
    logic [N-1:0]      rd_data_i;
    logic              conv_rst_o;
    logic              conv_en_o;
    logic [N-1:0]      conv_act_o;
    logic [N-1:0]      conv_data_i;
    logic              conv_val_i;
    logic              conv_done_i;
    logic              wr_en_o;
    logic [AW_OUT-1:0] wr_addr_o;
    logic [N-1:0]      wr_data_o;

    always #5 clk_i = ~clk_i;

    conv_sequencer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .relu_en_i   (relu_en_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .conv_rst_o  (conv_rst_o),
        .conv_en_o   (conv_en_o),
        .conv_act_o  (conv_act_o),
        .conv_data_i (conv_data_i),
        .conv_val_i  (conv_val_i),
        .conv_done_i (conv_done_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    fix_t ram [NUM_ACT];
    wr_t  exp_q [$];
    int   errors = 0;
    int   checks = 0;
    int   writes_seen = 0;
    int   dones_seen = 0;
    int   reads_seen = 0;
    int   exp_rd = 0;
    int   stub_limit = NUM_OUT;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // RAM read port (1-cycle latency) and convolver stub. The stub records
    // each enabled activation by position; when a k*k window is complete it
    // emits the window sum two cycles later. With the full result count it
    // raises done together with the last result; with a short count it
    // raises done one cycle after its final result. Done is held until clear.
    initial begin : env_model
        fix_t amem [NUM_ACT];
        logic pv [2];
        fix_t pd [2];
        int   pos;
        int   nres;
        int   nout;
        int   s;
        pos = 0; nres = 0; nout = 0;
        pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
        rd_data_i   = '0;
        conv_val_i  = 1'b0;
        conv_data_i = '0;
        conv_done_i = 1'b0;
        forever begin
            @(posedge clk_i);
            if (rd_en_o) begin
                rd_data_i <= (int'(rd_addr_o) < NUM_ACT) ? ram[int'(rd_addr_o)] : '0;
            end
            if (conv_rst_o) begin
                pos = 0; nres = 0; nout = 0;
                pv[0] = 1'b0; pv[1] = 1'b0;
                conv_val_i  <= 1'b0;
                conv_data_i <= '0;
                conv_done_i <= 1'b0;
            end else begin
                conv_val_i  <= pv[1];
                conv_data_i <= pd[1];
                if (pv[1]) begin
                    nout++;
                    if ((stub_limit == NUM_OUT) && (nout == stub_limit)) conv_done_i <= 1'b1;
                end else if ((stub_limit < NUM_OUT) && (nout == stub_limit)) begin
                    conv_done_i <= 1'b1;
                end
                pv[1] = pv[0];
                pd[1] = pd[0];
                pv[0] = 1'b0;
                if (conv_en_o && (pos < NUM_ACT)) begin
                    amem[pos] = conv_act_o;
                    if ((pos / n >= k - 1) && (pos % n >= k - 1) && (nres < stub_limit)) begin
                        s = 0;
                        for (int i = 0; i < k; i++)
                            for (int j = 0; j < k; j++)
                                s += int'(amem[(pos / n - k + 1 + i) * n + (pos % n - k + 1 + j)]);
                        pv[0] = 1'b1;
                        pd[0] = fix_t'(s);
                        nres++;
                    end
                    pos++;
                end
            end
        end
    end

    // Monitor: read addresses must run contiguously from 0 after each clear;
    // every write must match the head of the scoreboard.
    initial begin : monitor
        wr_t  e;
        fix_t wd;
        forever begin
            @(negedge clk_i);
            if (conv_rst_o) exp_rd = 0;
            if (rd_en_o) begin
                reads_seen++;
                checkOutput("rd_addr", int'(rd_addr_o), exp_rd);
                exp_rd++;
            end
            if (wr_en_o) begin
                writes_seen++;
                wd = wr_data_o;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr=%0d data=%0d, expected no write",
                             wr_addr_o, int'(wd));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", int'(wr_addr_o), e.addr);
                    checkOutput("wr_data", int'(wd), e.data);
                end
            end
            if (done_o) dones_seen++;
        end
    end

    // Reference: output (r,c) is the sum of the k*k RAM window at (r,c).
    task automatic buildExpected(input bit relu, input int limit);
        int s;
        wr_t e;
        exp_q.delete();
        for (int o = 0; o < limit; o++) begin
            s = 0;
            for (int i = 0; i < k; i++)
                for (int j = 0; j < k; j++)
                    s += int'(ram[(o / M + i) * n + (o % M + j)]);
            if (relu && s < 0) s = 0;
            e.addr = o;
            e.data = s;
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit relu, input int limit, input bit timing_chk, input bit poke);
        int   cyc;
        fix_t a;
        buildExpected(relu, limit);
        stub_limit  = limit;
        writes_seen = 0;
        dones_seen  = 0;
        reads_seen  = 0;
        @(negedge clk_i);
        start_i   = 1'b1;
        relu_en_i = relu;
        @(negedge clk_i);
        start_i   = 1'b0;
        relu_en_i = ~relu;
        if (timing_chk) begin
            checkOutput("clear_pulse", int'(conv_rst_o), 1);
            checkOutput("clear_busy", int'(busy_o), 1);
            for (int i = 0; i < NUM_ACT; i++) begin
                @(negedge clk_i);
                a = conv_act_o;
                checkOutput("stream_rd_en", int'(rd_en_o), 1);
                checkOutput("stream_conv_en", int'(conv_en_o), (i > 0) ? 1 : 0);
                if (i > 0) checkOutput("stream_act", int'(a), int'(ram[i - 1]));
            end
            @(negedge clk_i);
            a = conv_act_o;
            checkOutput("drain_rd_en", int'(rd_en_o), 0);
            checkOutput("drain_conv_en", int'(conv_en_o), 1);
            checkOutput("drain_last_act", int'(a), int'(ram[NUM_ACT - 1]));
        end
        if (poke) begin
            repeat ($urandom_range(3, 20)) @(negedge clk_i);
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
        end
        cyc = 0;
        while (busy_o && cyc < 1000) begin
            @(negedge clk_i);
            cyc++;
        end
        checkOutput("pass_timeout", (cyc < 1000) ? 0 : 1, 0);
        @(negedge clk_i);
        checkOutput("reads", reads_seen, NUM_ACT);
        checkOutput("writes", writes_seen, limit);
        checkOutput("pending_writes", exp_q.size(), 0);
        checkOutput("done_pulses", dones_seen, 1);
        checkOutput("err", int'(err_o), (limit < NUM_OUT) ? 1 : 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, int'(busy_o), 0);
        checkOutput({tag, "_done"}, int'(done_o), 0);
        checkOutput({tag, "_err"}, int'(err_o), 0);
        checkOutput({tag, "_rd_en"}, int'(rd_en_o), 0);
        checkOutput({tag, "_rd_addr"}, int'(rd_addr_o), 0);
        checkOutput({tag, "_conv_rst"}, int'(conv_rst_o), 1);
        checkOutput({tag, "_conv_en"}, int'(conv_en_o), 0);
        checkOutput({tag, "_conv_act"}, int'(conv_act_o), 0);
        checkOutput({tag, "_wr_en"}, int'(wr_en_o), 0);
        checkOutput({tag, "_wr_addr"}, int'(wr_addr_o), 0);
        checkOutput({tag, "_wr_data"}, int'(wr_data_o), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : main
        int cyc;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; relu_en_i = 1'b0;
        for (int i = 0; i < NUM_ACT; i++) ram[i] = fix_t'(i);
        repeat (2) @(negedge clk_i);
        checkResetValues("por");
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] ramp pass with timing checks");
        applyStimulus(1'b0, NUM_OUT, 1'b1, 1'b0);

        $display("[TB] negative ramp, relu on then off");
        for (int i = 0; i < NUM_ACT; i++) ram[i] = fix_t'(-i);
        applyStimulus(1'b1, NUM_OUT, 1'b0, 1'b0);
        applyStimulus(1'b0, NUM_OUT, 1'b0, 1'b0);

        $display("[TB] convolver done after 5 results");
        for (int i = 0; i < NUM_ACT; i++) ram[i] = fix_t'(i);
        applyStimulus(1'b0, 5, 1'b0, 1'b0);

        $display("[TB] abort during stream");
        exp_q.delete();
        stub_limit = NUM_OUT;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 0;
        while (!(rd_en_o && rd_addr_o == AW_IN'(10)) && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        checkOutput("abort_point", (rd_en_o && rd_addr_o == AW_IN'(10)) ? 1 : 0, 1);
        abort_i = 1'b1;
        @(posedge clk_i);
        exp_q.delete();
        writes_seen = 0; dones_seen = 0; reads_seen = 0;
        @(negedge clk_i);
        abort_i = 1'b0;
        checkOutput("abort_busy", int'(busy_o), 0);
        checkOutput("abort_conv_rst", int'(conv_rst_o), 1);
        checkOutput("abort_conv_en", int'(conv_en_o), 0);
        checkOutput("abort_err", int'(err_o), 0);
        repeat (40) @(negedge clk_i);
        checkOutput("abort_reads", reads_seen, 0);
        checkOutput("abort_writes", writes_seen, 0);
        checkOutput("abort_dones", dones_seen, 0);
        applyStimulus(1'b0, NUM_OUT, 1'b0, 1'b0);

        $display("[TB] start ignored while busy");
        applyStimulus(1'b0, NUM_OUT, 1'b0, 1'b1);

        $display("[TB] reset during drain");
        buildExpected(1'b0, NUM_OUT);
        stub_limit = NUM_OUT;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 0;
        while (!(busy_o && !rd_en_o && conv_en_o) && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        checkOutput("drain_reached", (busy_o && !rd_en_o && conv_en_o) ? 1 : 0, 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        exp_q.delete();
        @(negedge clk_i);
        checkResetValues("midrst");
        rst_i = 1'b0;
        writes_seen = 0;
        repeat (20) @(negedge clk_i);
        checkOutput("midrst_writes", writes_seen, 0);
        applyStimulus(1'b1, NUM_OUT, 1'b0, 1'b0);

        $display("[TB] random passes");
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < NUM_ACT; i++) ram[i] = fix_t'(int'($urandom_range(6000)) - 3000);
            applyStimulus(1'($urandom_range(1)), NUM_OUT, 1'b0, 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
